// File: rtl/xor_bist_pkg.sv
// Shared types and constants for the XOR/XNOR cell BIST controller.
package xor_bist_pkg;

  // Controller states; the encoding is visible to anything that imports this package.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } bist_state_e;

  // Input vectors {a,b} in the order they are applied within a round.
  localparam logic [1:0] VEC_00 = 2'b00;
  localparam logic [1:0] VEC_01 = 2'b01;
  localparam logic [1:0] VEC_10 = 2'b10;
  localparam logic [1:0] VEC_11 = 2'b11;

  // Error counter ceiling.
  localparam logic [3:0] ERR_MAX = 4'd15;

  // Map a vector index onto its {a,b} pattern.
  function automatic logic [1:0] vec_pattern(input logic [1:0] idx);
    logic [1:0] pat;
    pat = VEC_00;
    case (idx)
      2'd0:    pat = VEC_00;
      2'd1:    pat = VEC_01;
      2'd2:    pat = VEC_10;
      default: pat = VEC_11;
    endcase
    return pat;
  endfunction

  // Increment that sticks at ERR_MAX.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == ERR_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// Loadable down-counter: after a load it reports expired during the
// CYCLES-th following cycle, so a consumer that leaves its wait state on
// expired_o spends exactly CYCLES cycles there.
module bist_settle_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(CYCLES) + 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on request, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/xor_xnor_bist_ctrl.sv
// BIST controller for one XOR/XNOR cell: walks the four input vectors for
// ROUNDS passes, samples both cell outputs after a settle delay and
// reports pass/fail, the first failing vector and a saturating error count.
//
// Handshake: start is a level request that is only looked at in IDLE; the
// run it launches is reported by a single-cycle done pulse, with pass,
// err_count and fail_vec valid from that cycle until the next accepted start.
module xor_xnor_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ROUNDS        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [1:0] fail_vec,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_xor,
  input  logic       dut_xnor
);

  import xor_bist_pkg::*;

  localparam int unsigned RW = $clog2(ROUNDS) + 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  bist_state_e   state_q;
  logic [1:0]    vec_q;
  logic [RW-1:0] round_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [3:0]    err_q;
  logic [3:0]    err_d;
  logic [1:0]    fail_q;
  logic          a_q;
  logic          b_q;

  logic          settle_load;
  logic          settle_expired;
  logic          exp_xor;
  logic          exp_xnor;
  logic          mismatch;
  logic [1:0]    vec_nxt;
  logic [1:0]    pat_nxt;
  logic          last_sample;

  // The settle timer is loaded while in APPLY and counts through SETTLE.
  assign settle_load = (state_q == ST_APPLY);

  bist_settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk       (clk),
    .rst       (rst),
    .load_i    (settle_load),
    .expired_o (settle_expired)
  );

  // Compare the cell against the vector currently driven. Case inequality
  // makes an X or Z on either output count as a mismatch in simulation;
  // hardware only ever sees 0/1 so it reduces to a plain compare.
  always_comb begin
    exp_xor  = a_q ^ b_q;
    exp_xnor = ~(a_q ^ b_q);
    mismatch = (dut_xor !== exp_xor) || (dut_xnor !== exp_xnor);
  end

  // Next vector, whether this sample closes the run, and the error count
  // after this sample (one count per vector regardless of which output failed).
  always_comb begin
    vec_nxt     = vec_q + 2'd1;
    pat_nxt     = vec_pattern(vec_nxt);
    last_sample = (vec_q == 2'd3) && (round_q == LAST_ROUND);
    err_d       = err_q;
    if ((state_q == ST_SAMPLE) && mismatch) begin
      err_d = sat_inc(err_q);
    end
  end

  // Main FSM with registered status and cell drive. The cell inputs are
  // loaded on the edge that enters APPLY, so each vector is stable through
  // APPLY, SETTLE and SAMPLE and the sample lands on its last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fail_q  <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_APPLY;
            busy_q  <= 1'b1;
            vec_q   <= 2'd0;
            round_q <= '0;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            fail_q  <= 2'd0;
            a_q     <= VEC_00[1];
            b_q     <= VEC_00[0];
          end
        end
        ST_APPLY: begin
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_expired) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          err_q <= err_d;
          if (mismatch && (err_q == 4'd0)) begin
            fail_q <= {a_q, b_q};
          end
          if (last_sample) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 4'd0);
          end else begin
            state_q <= ST_APPLY;
            vec_q   <= vec_nxt;
            a_q     <= pat_nxt[1];
            b_q     <= pat_nxt[0];
            if (vec_q == 2'd3) begin
              round_q <= round_q + RW'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
  assign dut_a     = a_q;
  assign dut_b     = b_q;

endmodule

// File: doc/xor_xnor_bist_ctrl.md
# xor_xnor_bist_ctrl

Built-in self-test controller for the transistor-level XOR/XNOR cell. On a start request it walks the cell through all four input vectors, waits a programmable settle time, samples both outputs, and checks them against expected values. It reports pass/fail, the first failing vector and a saturating error count. It sits between the test/config logic and one cell instance, and owns that cell's inputs while a run is in progress.

## Interface
- `SETTLE_CYCLES`, default 2: cycles between applying a vector and sampling it; must be at least 1.
- `ROUNDS`, default 1: number of full passes over the four vectors; must be at least 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request, sampled in IDLE only.
- `busy`  out  1  high while the run is in progress (APPLY/SETTLE/SAMPLE).
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  result of last run; valid from `done`, held until next accepted start.
- `err_count`  out  4  mismatches in current/last run; saturates at 15.
- `fail_vec`  out  2  {a,b} of first mismatching vector; 0 if none.
- `dut_a`, `dut_b`  out  1 each  registered drive to the cell inputs.
- `dut_xor`, `dut_xnor`  in  1 each  cell outputs.

## Operation
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE: `start`=1 → APPLY. On this transition, clear `err_count`, `fail_vec`, `pass`, the vector index and the round counter.
- APPLY: register `dut_a`/`dut_b` from the vector index, then go to SETTLE and load the settle counter.
- SETTLE: stay for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: compare `dut_xor` with a^b and `dut_xnor` with ~(a^b), using the currently driven a/b.
    - Any mismatch on either output counts once per vector. X or Z on either output counts as a mismatch.
    - On a mismatch: `err_count`+1 (saturating). If this is the first mismatch of the run, capture `fail_vec`.
    - Next state: if vector=3 and round=ROUNDS-1, go to DONE. Otherwise advance the vector (3 wraps to 0 and the round increments) and go to APPLY.
- DONE: `done`=1 and `pass`←(`err_count`==0), then go to IDLE. `start` is ignored in this state.
- Vector order within a round: 00, 01, 10, 11.
- `start` while `busy` is ignored. If `start` is held high, a new run begins on the IDLE cycle after DONE.
- `dut_a`/`dut_b` keep their last values after a run completes.
- Reset values: all outputs 0, state IDLE.

## Timing
- The start accepted at edge k makes `busy` go high in cycle k+1.
- Each vector takes SETTLE_CYCLES+2 cycles.
- `done` is high in cycle k+1+4·ROUNDS·(SETTLE_CYCLES+2), and `busy` is low in that same cycle. Defaults: `done` at k+17.
- `err_count` and `fail_vec` update on the edge that ends SAMPLE.
- `pass` updates on the edge entering DONE, so it is visible together with `done`.
- Minimum gap between consecutive runs: IDLE→APPLY needs one IDLE cycle after DONE.
- `rst` asserted mid-run: outputs go to reset values immediately (asynchronous), the run is aborted, and no `done` is issued. After release, the block waits in IDLE for a fresh `start`.
- Widths:
    - vector index: 2 bits.
    - round counter: $clog2(ROUNDS)+1 bits.
    - settle counter: $clog2(SETTLE_CYCLES)+1 bits.

## Structure
- Package `xor_bist_pkg`: the FSM state enum, the vector constants 00..11, and the `ERR_MAX`=15 constant.
- Sub-module `bist_settle_timer`: loadable down-counter with a `load`/`expired` interface, reused by other cell BIST controllers.
- The cell itself is not instantiated here. The wrapper connects `dut_*` to a `cmos_xor_xnor` instance.

## Test plan
- Good cell, defaults; `start` pulse at cycle 0 → `busy` 1..16, `done` at cycle 17, `pass`=1, `err_count`=0, `fail_vec`=00.
- Cell model with `dut_xor` stuck-at-0 → `err_count`=2, `fail_vec`=01, `pass`=0.
- `dut_xnor` left floating (Z) → `err_count`=4, `fail_vec`=00, `pass`=0.
- ROUNDS=8, both outputs inverted → 32 mismatches; `err_count` saturates at 15, `done` at cycle 129.
- Extra `start` pulses at cycles 3 and 17 → exactly one run and one `done`. Then `rst` at cycle 8 of a second run → all outputs 0 immediately and no `done`; a new `start` after release runs a full 16-cycle sequence.
- Monitor `dut_a`/`dut_b` with SETTLE_CYCLES=3 → the vectors 00, 01, 10, 11 are each held 5 cycles, and each sample is taken on the last of those cycles.
